text_scan_engine: RTL and testbench

Parametrised text-mode scan-out engine for the VGA path. In the system clock domain it reads character/attribute words from video RAM over a single-master bus and resolves glyph rows through an external font ROM. Results go into a ping-pong line buffer one scanline ahead of display. In the pixel clock domain it serialises the buffered rows into RGB, with per-cell foreground and background colours from a fixed 16-colour palette.

---
 rtl/text_scan_engine_if.sv | 9 +
 rtl/text_scan_engine.sv | 215 +++++++++++++++++++++
 tb/tb_text_scan_engine.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/text_scan_engine_if.sv
// Single-master read bus the text scan engine uses to fetch cell words from video RAM.
interface text_scan_engine_if;
   logic        cyc_o;
   logic [31:0] adr_o;
   logic [31:0] dat_i;
   logic        ack_i;
   modport master (output cyc_o, adr_o, input  dat_i, ack_i);
   modport slave  (input  cyc_o, adr_o, output dat_i, ack_i);
endinterface

// File: rtl/text_scan_engine.sv
// Text-mode scan-out: fetches one scanline ahead into a ping-pong buffer (clk_i), serialises to RGB (pix_clk).
// Optional blinking/solid cursor cell inversion is built only when TEXT_CURSOR_EN is defined.
module text_scan_engine #(
   parameter int BPP     = 8,
   parameter int COLS    = 80,
   parameter int ROWS    = 60,
   parameter int FONT_H  = 8,
   parameter int BLINK_W = 25
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               pix_clk,
   input  logic [15:0]        x_i,
   input  logic [15:0]        y_i,
   input  logic               de_i,
   input  logic [31:0]        base_i,
   output logic [BPP-1:0]     r_o,
   output logic [BPP-1:0]     g_o,
   output logic [BPP-1:0]     b_o,
   text_scan_engine_if.master bus,
   output logic [11:0]        font0_adr_o,
   output logic [11:0]        font1_adr_o,
   input  logic [7:0]         font0_dat_i,
   input  logic [7:0]         font1_dat_i,
   output logic               overrun_o,
   input  logic [7:0]         cursor_row_i,
   input  logic [7:0]         cursor_col_i,
   input  logic [1:0]         cursor_mode_i
);
   localparam int              HALF  = COLS / 2;
   localparam int              WW    = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [15:0]     LINES = 16'(ROWS * FONT_H);
   localparam logic [WW-1:0]   LAST  = WW'(HALF - 1);

   // Reset asserts asynchronously in both domains, releases on each domain's own clock.
   logic [1:0] rs_sys, rs_pix;
   logic       rst_s, rst_p;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) rs_sys <= 2'b11;
      else       rs_sys <= {rs_sys[0], 1'b0};
   always_ff @(posedge pix_clk or posedge rst_i)
      if (rst_i) rs_pix <= 2'b11;
      else       rs_pix <= {rs_pix[0], 1'b0};
   assign rst_s = rs_sys[1];
   assign rst_p = rs_pix[1];

   // Pixel side: every new scanline requests the following one (wrapping at the frame end).
   logic [15:0] y_prev, tgt, y_nx;
   logic        req_tgl;
   assign y_nx = y_i + 16'd1;
   always_ff @(posedge pix_clk or posedge rst_p)
      if (rst_p) begin
         y_prev  <= '0;
         tgt     <= '0;
         req_tgl <= 1'b0;
      end else if (y_i != y_prev) begin
         y_prev  <= y_i;
         tgt     <= (y_nx >= LINES) ? 16'd0 : y_nx;
         req_tgl <= ~req_tgl;
      end

   typedef enum logic [1:0] {IDLE, BUS, FONT, STORE} state_t;
   state_t        state, nxt;
   logic [2:0]    req_sync;
   logic          req_edge, pend, restart, go_new;
   logic [15:0]   line_q, attr_q;
   logic [WW-1:0] w;
   logic [3:0]    frow;
   logic [31:0]   row_base;

   assign req_edge = req_sync[2] ^ req_sync[1];
   assign restart  = pend | req_edge;
   assign frow     = 4'(line_q % 16'(FONT_H));
   assign row_base = 32'(line_q / 16'(FONT_H)) * 32'(COLS * 2);

   always_ff @(posedge clk_i or posedge rst_s)
      if (rst_s) state <= IDLE;
      else       state <= nxt;

   always_comb begin
      nxt    = state;
      go_new = 1'b0;
      case (state)
         IDLE:  if (req_edge) begin nxt = BUS; go_new = 1'b1; end
         BUS:   if (bus.ack_i) begin
                   nxt    = restart ? BUS : FONT;
                   go_new = restart;
                end
         FONT:  begin nxt = restart ? BUS : STORE; go_new = restart; end
         STORE: begin
                   if (restart)        begin nxt = BUS; go_new = 1'b1; end
                   else if (w == LAST) nxt = IDLE;
                   else                nxt = BUS;
                end
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.cyc_o = 1'b0;
      bus.adr_o = '0;
      if (state == BUS) begin
         bus.cyc_o = 1'b1;
         bus.adr_o = base_i + row_base + 32'({w, 2'b00});
      end
   end

   // A request landing mid-fetch is remembered and honoured once the bus cycle in flight ends.
   always_ff @(posedge clk_i or posedge rst_s)
      if (rst_s) begin
         req_sync    <= '0;
         line_q      <= '0;
         w           <= '0;
         pend        <= 1'b0;
         overrun_o   <= 1'b0;
         attr_q      <= '0;
         font0_adr_o <= '0;
         font1_adr_o <= '0;
      end else begin
         req_sync <= {req_sync[1:0], req_tgl};
         if (req_edge && state != IDLE) overrun_o <= 1'b1;
         if (go_new) begin
            line_q <= tgt;
            w      <= '0;
            pend   <= 1'b0;
         end else begin
            if (req_edge && state != IDLE) pend <= 1'b1;
            if (state == STORE && nxt == BUS) w <= w + WW'(1);
         end
         if (state == BUS && bus.ack_i) begin
            attr_q      <= {bus.dat_i[31:24], bus.dat_i[15:8]};
            font0_adr_o <= {bus.dat_i[23:16], frow};
            font1_adr_o <= {bus.dat_i[7:0], frow};
         end
      end

   logic [31:0] lbuf [2][HALF];
   always_ff @(posedge clk_i)
      if (state == STORE) lbuf[line_q[0]][w] <= {attr_q, font0_dat_i, font1_dat_i};

   logic cur_hit;
`ifdef TEXT_CURSOR_EN
   logic [BLINK_W-1:0] blink_cnt;
   logic [1:0]         blink_s;
   always_ff @(posedge clk_i or posedge rst_s)
      if (rst_s) blink_cnt <= '0;
      else       blink_cnt <= blink_cnt + BLINK_W'(1);
   always_ff @(posedge pix_clk or posedge rst_p)
      if (rst_p) blink_s <= '0;
      else       blink_s <= {blink_s[0], blink_cnt[BLINK_W-1]};
   assign cur_hit = (y_i / 16'(FONT_H) == {8'h00, cursor_row_i}) &&
                    (x_i[15:3] == {5'h00, cursor_col_i}) &&
                    (cursor_mode_i == 2'd2 || (cursor_mode_i == 2'd1 && blink_s[1]));
`else
   assign cur_hit = 1'b0;
   wire unused_cursor = &{1'b0, cursor_row_i, cursor_col_i, cursor_mode_i, (BLINK_W > 0)};
`endif

   // Stage 1: buffer read for the 16-pixel column pair, plus the per-pixel side info.
   logic [WW-1:0] cidx;
   logic [31:0]   rd1;
   logic [3:0]    x1;
   logic          de1, cur1;
   assign cidx = WW'(x_i[15:4] % 12'(HALF));
   always_ff @(posedge pix_clk)
      rd1 <= lbuf[y_i[0]][cidx];
   always_ff @(posedge pix_clk or posedge rst_p)
      if (rst_p) begin
         x1   <= '0;
         de1  <= 1'b0;
         cur1 <= 1'b0;
      end else begin
         x1   <= x_i[3:0];
         de1  <= de_i;
         cur1 <= cur_hit;
      end

   function automatic logic [BPP-1:0] comp(input logic c, input logic i);
      logic [BPP-1:0] v;
      v = '0;
      if (c && i)  v = '1;
      else if (c)  v[BPP-1] = 1'b1;
      else if (i)  v[BPP-2] = 1'b1;
      return v;
   endfunction

   // Stage 2: pick the glyph bit and the cell's colour pair, then map through the palette.
   logic [15:0] bits;
   logic [7:0]  attr;
   logic [3:0]  fg, bg, idx;
   logic        px;
   always_comb begin
      bits = rd1[15:0];
      px   = bits[4'd15 - x1];
      attr = x1[3] ? rd1[23:16] : rd1[31:24];
      fg   = cur1 ? attr[3:0] : attr[7:4];
      bg   = cur1 ? attr[7:4] : attr[3:0];
      idx  = px ? fg : bg;
   end

   always_ff @(posedge pix_clk or posedge rst_p)
      if (rst_p) begin
         r_o <= '0;
         g_o <= '0;
         b_o <= '0;
      end else if (de1) begin
         r_o <= comp(idx[2], idx[3]);
         g_o <= comp(idx[1], idx[3]);
         b_o <= comp(idx[0], idx[3]);
      end else begin
         r_o <= '0;
         g_o <= '0;
         b_o <= '0;
      end
endmodule

// File: tb/tb_text_scan_engine.sv
// Directed bench for text_scan_engine: bus/VRAM and font ROM models, per-scenario tasks with inline checks.
module tb_text_scan_engine;
   logic        clk_i = 1'b0, pix_clk = 1'b0, rst_i = 1'b1;
   logic [15:0] x_i = '0, y_i = '0;
   logic        de_i = 1'b0;
   logic [31:0] base_i = 32'h1000;
   logic [7:0]  r_o, g_o, b_o;
   logic [11:0] font0_adr_o, font1_adr_o;
   logic [7:0]  font0_dat_i, font1_dat_i;
   logic        overrun_o;
   logic [7:0]  cursor_row_i = '0, cursor_col_i = '0;
   logic [1:0]  cursor_mode_i = '0;
   logic        stall = 1'b0;
   logic        frow_chk;
   logic [31:0] adr_log [$];
   logic [3:0]  frow_log [$];
   int          n_checks = 0, n_fail = 0;

   text_scan_engine_if bus ();

   text_scan_engine #(.BPP(8), .COLS(80), .ROWS(60), .FONT_H(8), .BLINK_W(6)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .pix_clk(pix_clk),
      .x_i(x_i), .y_i(y_i), .de_i(de_i), .base_i(base_i),
      .r_o(r_o), .g_o(g_o), .b_o(b_o), .bus(bus),
      .font0_adr_o(font0_adr_o), .font1_adr_o(font1_adr_o),
      .font0_dat_i(font0_dat_i), .font1_dat_i(font1_dat_i),
      .overrun_o(overrun_o),
      .cursor_row_i(cursor_row_i), .cursor_col_i(cursor_col_i), .cursor_mode_i(cursor_mode_i));

   always #5 clk_i = ~clk_i;
   always #7 pix_clk = ~pix_clk;

   function automatic logic [31:0] vram(input logic [31:0] a);
      return (a == 32'h1000) ? 32'h4F41_1F42 : 32'h1E00_2C00;
   endfunction

   function automatic logic [7:0] rom(input logic [11:0] a);
      if (a[11:4] == 8'h41) return 8'hFF;
      if (a[11:4] == 8'h42) return 8'h00;
      return 8'hA5 ^ {4'h0, a[3:0]};
   endfunction

   always @(posedge clk_i) begin
      bus.ack_i   <= bus.cyc_o && !bus.ack_i && !stall;
      bus.dat_i   <= vram(bus.adr_o);
      font0_dat_i <= rom(font0_adr_o);
      font1_dat_i <= rom(font1_adr_o);
      if (bus.cyc_o && bus.ack_i) adr_log.push_back(bus.adr_o);
      frow_chk <= bus.cyc_o && bus.ack_i;
      if (frow_chk) frow_log.push_back(font0_adr_o[3:0]);
   end

   task automatic set_y(input logic [15:0] v);
      @(negedge pix_clk);
      y_i = v;
   endtask

   task automatic wait_reads(input int n);
      for (int k = 0; k < 3000 && adr_log.size() < n; k++) @(posedge clk_i);
      repeat (8) @(posedge clk_i);
   endtask

   task automatic pix(input logic [15:0] x, input logic de);
      @(negedge pix_clk);
      x_i = x;
      de_i = de;
      @(posedge pix_clk);
      @(posedge pix_clk);
      #1;
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      #40;
      n_checks++; if (bus.cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc got %b want 0", bus.cyc_o); end
      n_checks++; if (bus.adr_o !== 32'h0) begin n_fail++; $display("FAIL reset_adr got %h want 0", bus.adr_o); end
      n_checks++; if (font0_adr_o !== 12'h0) begin n_fail++; $display("FAIL reset_f0 got %h want 0", font0_adr_o); end
      n_checks++; if (font1_adr_o !== 12'h0) begin n_fail++; $display("FAIL reset_f1 got %h want 0", font1_adr_o); end
      n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got %b want 0", overrun_o); end
      n_checks++; if ({r_o, g_o, b_o} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb got %h want 0", {r_o, g_o, b_o}); end
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (6) @(posedge clk_i);
   endtask

   task automatic test_fetch;
      set_y(16'd7);
      wait_reads(40);
      adr_log.delete();
      frow_log.delete();
      set_y(16'd8);
      wait_reads(40);
      n_checks++; if (adr_log.size() != 40) begin n_fail++; $display("FAIL fetch_count got %0d want 40", adr_log.size()); end
      for (int i = 0; i < adr_log.size() && i < 40; i++) begin
         n_checks++;
         if (adr_log[i] !== 32'h10A0 + 32'(4 * i)) begin
            n_fail++; $display("FAIL fetch_adr[%0d] got %h want %h", i, adr_log[i], 32'h10A0 + 32'(4 * i));
         end
      end
      for (int i = 0; i < frow_log.size() && i < 40; i++) begin
         n_checks++;
         if (frow_log[i] !== 4'd1) begin n_fail++; $display("FAIL fetch_frow[%0d] got %0d want 1", i, frow_log[i]); end
      end
      n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL fetch_ovr got %b want 0", overrun_o); end
   endtask

   task automatic test_wrap;
      adr_log.delete();
      frow_log.delete();
      set_y(16'd479);
      wait_reads(40);
      n_checks++; if (adr_log.size() != 40) begin n_fail++; $display("FAIL wrap_count got %0d want 40", adr_log.size()); end
      if (adr_log.size() == 40) begin
         n_checks++; if (adr_log[0] !== 32'h1000) begin n_fail++; $display("FAIL wrap_first got %h want 1000", adr_log[0]); end
         n_checks++; if (adr_log[39] !== 32'h109C) begin n_fail++; $display("FAIL wrap_last got %h want 109c", adr_log[39]); end
      end
      if (frow_log.size() > 0) begin
         n_checks++; if (frow_log[0] !== 4'd0) begin n_fail++; $display("FAIL wrap_frow got %0d want 0", frow_log[0]); end
      end
      set_y(16'd0);
      wait_reads(80);
   endtask

   task automatic test_pixels;
      logic [15:0] vx [12] = '{16'd0, 16'd7, 16'd8, 16'd15, 16'd16, 16'd17, 16'd24, 16'd25,
                               16'd640, 16'd648, 16'd0, 16'd8};
      logic        vde [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [23:0] vexp [12] = '{24'h800000, 24'h800000, 24'hFFFFFF, 24'hFFFFFF, 24'h000080, 24'hFFFF40,
                                 24'h008000, 24'hFF4040, 24'h800000, 24'hFFFFFF, 24'h000000, 24'h000000};
      for (int i = 0; i < 12; i++) begin
         pix(vx[i], vde[i]);
         n_checks++;
         if ({r_o, g_o, b_o} !== vexp[i]) begin
            n_fail++; $display("FAIL pixel x=%0d de=%b got %h want %h", vx[i], vde[i], {r_o, g_o, b_o}, vexp[i]);
         end
      end
   endtask

`ifdef TEXT_CURSOR_EN
   task automatic test_cursor;
      logic seen_on, seen_off;
      cursor_row_i = 8'd0;
      cursor_col_i = 8'd0;
      cursor_mode_i = 2'd2;
      pix(16'd0, 1'b1);
      n_checks++; if ({r_o, g_o, b_o} !== 24'hFFFFFF) begin n_fail++; $display("FAIL cursor_solid got %h want ffffff", {r_o, g_o, b_o}); end
      cursor_col_i = 8'd2;
      pix(16'd16, 1'b1);
      n_checks++; if ({r_o, g_o, b_o} !== 24'hFFFF40) begin n_fail++; $display("FAIL cursor_col2 got %h want ffff40", {r_o, g_o, b_o}); end
      pix(16'd0, 1'b1);
      n_checks++; if ({r_o, g_o, b_o} !== 24'h800000) begin n_fail++; $display("FAIL cursor_off_cell got %h want 800000", {r_o, g_o, b_o}); end
      cursor_col_i = 8'd0;
      cursor_mode_i = 2'd1;
      seen_on = 1'b0;
      seen_off = 1'b0;
      for (int k = 0; k < 200 && !(seen_on && seen_off); k++) begin
         pix(16'd0, 1'b1);
         if ({r_o, g_o, b_o} == 24'hFFFFFF) seen_on = 1'b1;
         else if ({r_o, g_o, b_o} == 24'h800000) seen_off = 1'b1;
      end
      n_checks++; if (seen_on !== 1'b1) begin n_fail++; $display("FAIL blink_on got %b want 1", seen_on); end
      n_checks++; if (seen_off !== 1'b1) begin n_fail++; $display("FAIL blink_off got %b want 1", seen_off); end
      cursor_mode_i = 2'd0;
   endtask
`endif

   task automatic test_overrun;
      adr_log.delete();
      stall = 1'b1;
      set_y(16'd15);
      repeat (20) @(posedge clk_i);
      #1;
      n_checks++; if (bus.cyc_o !== 1'b1) begin n_fail++; $display("FAIL ovr_cyc_early got %b want 1", bus.cyc_o); end
      n_checks++; if (bus.adr_o !== 32'h1140) begin n_fail++; $display("FAIL ovr_adr_early got %h want 1140", bus.adr_o); end
      set_y(16'd23);
      repeat (180) @(posedge clk_i);
      #1;
      n_checks++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", overrun_o); end
      n_checks++; if (bus.cyc_o !== 1'b1) begin n_fail++; $display("FAIL ovr_cyc_held got %b want 1", bus.cyc_o); end
      n_checks++; if (bus.adr_o !== 32'h1140) begin n_fail++; $display("FAIL ovr_adr_held got %h want 1140", bus.adr_o); end
      stall = 1'b0;
      wait_reads(41);
      n_checks++; if (adr_log.size() != 41) begin n_fail++; $display("FAIL ovr_count got %0d want 41", adr_log.size()); end
      if (adr_log.size() == 41) begin
         n_checks++; if (adr_log[0] !== 32'h1140) begin n_fail++; $display("FAIL ovr_first got %h want 1140", adr_log[0]); end
         n_checks++; if (adr_log[1] !== 32'h11E0) begin n_fail++; $display("FAIL ovr_restart got %h want 11e0", adr_log[1]); end
         n_checks++; if (adr_log[40] !== 32'h127C) begin n_fail++; $display("FAIL ovr_last got %h want 127c", adr_log[40]); end
      end
      n_checks++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b want 1", overrun_o); end
   endtask

   task automatic test_reset_mid_bus;
      stall = 1'b1;
      set_y(16'd31);
      repeat (20) @(posedge clk_i);
      #1;
      n_checks++; if (bus.cyc_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got %b want 1", bus.cyc_o); end
      @(negedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      n_checks++; if (bus.cyc_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_cyc got %b want 0", bus.cyc_o); end
      n_checks++; if (bus.adr_o !== 32'h0) begin n_fail++; $display("FAIL rst_mid_adr got %h want 0", bus.adr_o); end
      n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovr got %b want 0", overrun_o); end
      repeat (3) @(posedge clk_i);
      rst_i = 1'b0;
      stall = 1'b0;
      repeat (6) @(posedge clk_i);
   endtask

   initial begin
      test_reset;
      test_fetch;
      test_wrap;
      test_pixels;
`ifdef TEXT_CURSOR_EN
      test_cursor;
`endif
      test_overrun;
      test_reset_mid_bus;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired after %0d checks", n_checks);
      $fatal(1, "watchdog");
   end
endmodule
